palette_pixel_sched: RTL and testbench
======================================

Name: palette_pixel_sched

Overview:
- Per-pixel scheduler that feeds the VGA color palette stage.
- For each pixel strobe it sequences two reads from a shared, single-port sprite index ROM, one per sprite slot (player and enemy).
- It resolves layer priority between the chooser box, slot 0, slot 1 and the background.
- It drives registered palette_idx, is_background and is_chooser to the palette lookup with a fixed latency.

Parameters:
- SPR_W, 64, sprite width in pixels (power of two)
- SPR_H, 64, sprite height in pixels (power of two)
- ROM_AW, 13, ROM address width = 1 + log2(SPR_W*SPR_H)
- BOX_W, 64, chooser box width
- BOX_H, 64, chooser box height
- BOX_T, 2, chooser outline thickness

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous, active-low reset
- pixel_en  in  1  one-cycle pixel strobe
- DrawX  in  10  current pixel x
- DrawY  in  10  current pixel y
- cfg_we  in  1  config write strobe
- cfg_sel  in  2  config target: 0=slot0 pos, 1=slot1 pos, 2=chooser pos, 3=enables
- cfg_x  in  10  x value; for sel 3, bits[2:0] = {chooser_en, slot1_en, slot0_en}
- cfg_y  in  10  y value (ignored for sel 3)
- rom_addr  out  ROM_AW  sprite ROM address
- rom_data  in  5  sprite ROM palette index; 1-cycle synchronous read
- palette_idx  out  5  resolved palette index
- is_background  out  1  pixel is background
- is_chooser  out  1  pixel is chooser outline
- out_valid  out  1  one-cycle pulse when outputs update
- overrun  out  1  sticky: pixel_en was dropped

Behaviour:
- Reset values:
  - palette_idx=0, is_background=1, is_chooser=0, out_valid=0, rom_addr=0, overrun=0.
  - All positions are 0; all enables are 0.
  - FSM is in IDLE.
- Reset is asynchronous and active-low; the clock is Clk and the reset is Reset_n.
- Config:
  - A cfg_we write takes effect on the next Clk edge.
  - A pixel in flight uses the positions and enables sampled at its own pixel_en.
- FSM: IDLE -> RD0 -> RD1 -> RESOLVE -> IDLE.
- IDLE:
  - On pixel_en, latch DrawX/DrawY and compute hit flags and offsets for both slots and the chooser, then go to RD0.
- Slot hit test:
  - Hit when x0 <= DrawX < x0+SPR_W and y0 <= DrawY < y0+SPR_H, compared at 11 bits so there is no wrap.
  - dx = DrawX-x0, dy = DrawY-y0.
- RD0:
  - rom_addr = {1'b0, dy, dx} if slot0 hit and enabled, else 0.
- RD1:
  - Capture rom_data as d0, forced to 0 if there is no slot0 hit.
  - rom_addr = {1'b1, dy1, dx1} if slot1 hit and enabled, else 0.
- RESOLVE:
  - Capture d1 under the same rule as d0.
  - Register the outputs and pulse out_valid in the following cycle.
- Latency:
  - pixel_en sampled at edge N; out_valid is high during cycle N+4 exactly.
  - Outputs hold until the next update.
- Priority (highest first):
  - Chooser hit and chooser_en -> is_chooser=1, is_background=0, palette_idx=0.
  - d0 != 0 -> palette_idx=d0, is_background=0.
  - d1 != 0 -> palette_idx=d1, is_background=0.
  - Otherwise is_background=1, palette_idx=0.
- Transparency:
  - Index 0 is transparent.
- Chooser hit:
  - Inside the box cx <= DrawX < cx+BOX_W and cy <= DrawY < cy+BOX_H.
  - And within BOX_T of any edge (dx<BOX_T, dx>=BOX_W-BOX_T, dy<BOX_T or dy>=BOX_H-BOX_T).
  - The box interior is not a hit.
- Overrun:
  - pixel_en while not in IDLE is ignored and sets overrun=1.
  - overrun clears only on reset.
  - The in-flight pixel completes normally.
- Reset mid-operation:
  - The FSM returns to IDLE immediately and no out_valid is produced for the aborted pixel.
- Both slots disabled:
  - Both ROM reads are still issued with address 0, so latency is unchanged.

Optional Feature:
- Macro: CHOOSER_BLINK_EN.
- When defined:
  - A 6-bit frame counter increments on each accepted pixel_en with DrawX=0 and DrawY=0.
  - The chooser outline is suppressed when counter bit 5 = 1, i.e. it blinks with a 32-frame half-period.
  - While suppressed, chooser pixels fall through to sprite/background priority.
  - The counter resets to 0.
- When undefined:
  - No counter exists and the chooser is always shown when enabled.

Test Plan:
1. Reset_n low, then high with no stimulus -> is_background=1, palette_idx=0, is_chooser=0, out_valid=0, overrun=0, rom_addr=0.
2. Slot0 at (100,50), slot0_en=1, ROM[323]=7, pixel_en with DrawX=103, DrawY=55 -> rom_addr=323 at N+1, out_valid at N+4, palette_idx=7, is_background=0.
3. Slots 0 and 1 overlapping, d0=0 and d1=9 -> palette_idx=9; repeat with d0=4 -> palette_idx=4.
4. Chooser at (200,200), chooser_en=1:
   - DrawX=201, DrawY=230 -> is_chooser=1.
   - DrawX=210, DrawY=230 -> is_background=1.
   - Chooser overlapping slot0 with d0=7 -> is_chooser=1, palette_idx=0.
5. pixel_en at N and N+2 -> single out_valid at N+4, overrun=1 and it stays 1.
6. Boundaries and reset:
   - Slot0 x0=600: DrawX=663 -> hit; DrawX=664 -> miss, is_background=1.
   - Reset_n pulsed low in RD1 -> no out_valid, FSM in IDLE, next pixel_en completes at +4.

Source files
------------

// File: rtl/palette_pixel_sched.sv
// Per-pixel scheduler for the palette stage: two sprite ROM reads per pixel, then layer priority resolve.
// Optional build macro CHOOSER_BLINK_EN adds a frame counter that blinks the chooser outline.
module palette_pixel_sched #(
   parameter int SPR_W  = 64,
   parameter int SPR_H  = 64,
   parameter int ROM_AW = 13,
   parameter int BOX_W  = 64,
   parameter int BOX_H  = 64,
   parameter int BOX_T  = 2
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              pixel_en,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_sel,
   input  logic [9:0]        cfg_x,
   input  logic [9:0]        cfg_y,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [4:0]        rom_data,
   output logic [4:0]        palette_idx,
   output logic              is_background,
   output logic              is_chooser,
   output logic              out_valid,
   output logic              overrun,
   output logic [1:0]        o_dbg_state
);

   localparam int XW = $clog2(SPR_W);
   localparam int YW = $clog2(SPR_H);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD0     = 2'd1,
      S_RD1     = 2'd2,
      S_RESOLVE = 2'd3
   } state_t;

   state_t            r_state;
   logic [9:0]        r_x0, r_y0, r_x1, r_y1, r_cx, r_cy;
   logic [2:0]        r_en;
   logic              r_hit0, r_hit1, r_chit;
   logic [ROM_AW-1:0] r_addr1;
   logic [ROM_AW-1:0] r_rom_addr;
   logic [4:0]        r_d0;
   logic [4:0]        r_palette_idx;
   logic              r_is_bg, r_is_ch, r_out_valid, r_overrun;

   logic [10:0]       w_px, w_py;
   logic              w_hit0, w_hit1, w_cin, w_cedge, w_chit, w_show_ch;
   logic [XW-1:0]     w_dx0, w_dx1;
   logic [YW-1:0]     w_dy0, w_dy1;
   logic [10:0]       w_cdx, w_cdy;
   logic [ROM_AW-1:0] w_addr0, w_addr1;
   logic [4:0]        w_d1;

   // Compare at 11 bits so a sprite near the right/bottom edge cannot wrap.
   assign w_px   = {1'b0, DrawX};
   assign w_py   = {1'b0, DrawY};
   assign w_hit0 = r_en[0] &&
                   (w_px >= {1'b0, r_x0}) && (w_px < ({1'b0, r_x0} + 11'(SPR_W))) &&
                   (w_py >= {1'b0, r_y0}) && (w_py < ({1'b0, r_y0} + 11'(SPR_H)));
   assign w_hit1 = r_en[1] &&
                   (w_px >= {1'b0, r_x1}) && (w_px < ({1'b0, r_x1} + 11'(SPR_W))) &&
                   (w_py >= {1'b0, r_y1}) && (w_py < ({1'b0, r_y1} + 11'(SPR_H)));
   assign w_dx0  = DrawX[XW-1:0] - r_x0[XW-1:0];
   assign w_dy0  = DrawY[YW-1:0] - r_y0[YW-1:0];
   assign w_dx1  = DrawX[XW-1:0] - r_x1[XW-1:0];
   assign w_dy1  = DrawY[YW-1:0] - r_y1[YW-1:0];
   assign w_addr0 = w_hit0 ? ROM_AW'({1'b0, w_dy0, w_dx0}) : '0;
   assign w_addr1 = w_hit1 ? ROM_AW'({1'b1, w_dy1, w_dx1}) : '0;

   assign w_cdx   = w_px - {1'b0, r_cx};
   assign w_cdy   = w_py - {1'b0, r_cy};
   assign w_cin   = (w_px >= {1'b0, r_cx}) && (w_px < ({1'b0, r_cx} + 11'(BOX_W))) &&
                    (w_py >= {1'b0, r_cy}) && (w_py < ({1'b0, r_cy} + 11'(BOX_H)));
   assign w_cedge = (w_cdx < 11'(BOX_T)) || (w_cdx >= 11'(BOX_W - BOX_T)) ||
                    (w_cdy < 11'(BOX_T)) || (w_cdy >= 11'(BOX_H - BOX_T));

`ifdef CHOOSER_BLINK_EN
   logic [5:0] r_frame;
   assign w_show_ch = ~r_frame[5];
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_frame <= '0;
      end else if (pixel_en && r_state == S_IDLE && DrawX == 10'd0 && DrawY == 10'd0) begin
         r_frame <= r_frame + 6'd1;
      end
   end
`else
   assign w_show_ch = 1'b1;
`endif

   assign w_chit = r_en[2] && w_cin && w_cedge && w_show_ch;
   assign w_d1   = r_hit1 ? rom_data : 5'd0;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_x0 <= '0; r_y0 <= '0;
         r_x1 <= '0; r_y1 <= '0;
         r_cx <= '0; r_cy <= '0;
         r_en <= '0;
      end else if (cfg_we) begin
         case (cfg_sel)
            2'd0: begin r_x0 <= cfg_x; r_y0 <= cfg_y; end
            2'd1: begin r_x1 <= cfg_x; r_y1 <= cfg_y; end
            2'd2: begin r_cx <= cfg_x; r_cy <= cfg_y; end
            default: r_en <= cfg_x[2:0];
         endcase
      end
   end

   // The ROM address is registered one state ahead so each read lands in the next state.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state       <= S_IDLE;
         r_hit0        <= 1'b0;
         r_hit1        <= 1'b0;
         r_chit        <= 1'b0;
         r_addr1       <= '0;
         r_rom_addr    <= '0;
         r_d0          <= '0;
         r_palette_idx <= '0;
         r_is_bg       <= 1'b1;
         r_is_ch       <= 1'b0;
         r_out_valid   <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (pixel_en && r_state != S_IDLE) r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (pixel_en) begin
                  r_hit0     <= w_hit0;
                  r_hit1     <= w_hit1;
                  r_chit     <= w_chit;
                  r_addr1    <= w_addr1;
                  r_rom_addr <= w_addr0;
                  r_state    <= S_RD0;
               end
            end
            S_RD0: begin
               r_rom_addr <= r_addr1;
               r_state    <= S_RD1;
            end
            S_RD1: begin
               r_d0       <= r_hit0 ? rom_data : 5'd0;
               r_rom_addr <= '0;
               r_state    <= S_RESOLVE;
            end
            default: begin
               r_out_valid <= 1'b1;
               r_state     <= S_IDLE;
               if (r_chit) begin
                  r_is_ch       <= 1'b1;
                  r_is_bg       <= 1'b0;
                  r_palette_idx <= 5'd0;
               end else if (r_d0 != 5'd0) begin
                  r_is_ch       <= 1'b0;
                  r_is_bg       <= 1'b0;
                  r_palette_idx <= r_d0;
               end else if (w_d1 != 5'd0) begin
                  r_is_ch       <= 1'b0;
                  r_is_bg       <= 1'b0;
                  r_palette_idx <= w_d1;
               end else begin
                  r_is_ch       <= 1'b0;
                  r_is_bg       <= 1'b1;
                  r_palette_idx <= 5'd0;
               end
            end
         endcase
      end
   end

   assign rom_addr      = r_rom_addr;
   assign palette_idx   = r_palette_idx;
   assign is_background = r_is_bg;
   assign is_chooser    = r_is_ch;
   assign out_valid     = r_out_valid;
   assign overrun       = r_overrun;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_palette_pixel_sched.sv
// Directed bench for palette_pixel_sched with a behavioural synchronous sprite ROM.
module tb_palette_pixel_sched;

   logic        Clk;
   logic        Reset_n;
   logic        pixel_en;
   logic [9:0]  DrawX, DrawY;
   logic        cfg_we;
   logic [1:0]  cfg_sel;
   logic [9:0]  cfg_x, cfg_y;
   logic [12:0] rom_addr;
   logic [4:0]  rom_data;
   logic [4:0]  palette_idx;
   logic        is_background, is_chooser, out_valid, overrun;
   logic [1:0]  o_dbg_state;

   logic [4:0]  rom_mem [0:8191];

   int checks;
   int errors;

   logic [12:0] seen_addr0, seen_addr1;
   int          valid_at, valid_cnt;

   palette_pixel_sched dut (
      .Clk(Clk), .Reset_n(Reset_n), .pixel_en(pixel_en),
      .DrawX(DrawX), .DrawY(DrawY),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_x(cfg_x), .cfg_y(cfg_y),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .palette_idx(palette_idx), .is_background(is_background),
      .is_chooser(is_chooser), .out_valid(out_valid), .overrun(overrun),
      .o_dbg_state(o_dbg_state)
   );

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   always @(posedge Clk) rom_data <= rom_mem[rom_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic cfg(input logic [1:0] sel, input logic [9:0] x, input logic [9:0] y);
      @(negedge Clk);
      cfg_we = 1'b1; cfg_sel = sel; cfg_x = x; cfg_y = y;
      @(negedge Clk);
      cfg_we = 1'b0;
   endtask

   // Strobe one pixel and observe eight following negedges.
   task automatic pixel(input logic [9:0] x, input logic [9:0] y);
      @(negedge Clk);
      pixel_en = 1'b1; DrawX = x; DrawY = y;
      valid_at = 0; valid_cnt = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge Clk);
         pixel_en = 1'b0;
         if (i == 1) seen_addr0 = rom_addr;
         if (i == 2) seen_addr1 = rom_addr;
         if (out_valid) begin
            valid_cnt++;
            if (valid_at == 0) valid_at = i;
         end
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      for (int a = 0; a < 8192; a++) rom_mem[a] = 5'd0;
      Reset_n = 1'b0; pixel_en = 1'b0; DrawX = '0; DrawY = '0;
      cfg_we = 1'b0; cfg_sel = '0; cfg_x = '0; cfg_y = '0;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      repeat (3) @(negedge Clk);

      check("rst_bg", is_background, 1);
      check("rst_idx", palette_idx, 0);
      check("rst_ch", is_chooser, 0);
      check("rst_valid", out_valid, 0);
      check("rst_overrun", overrun, 0);
      check("rst_addr", rom_addr, 0);
      check("rst_state", o_dbg_state, 0);

      // Single sprite hit: dx=3, dy=5 -> address 323
      rom_mem[323] = 5'd7;
      cfg(2'd0, 10'd100, 10'd50);
      cfg(2'd3, 10'd1, 10'd0);
      pixel(10'd103, 10'd55);
      check("s0_addr", seen_addr0, 323);
      check("s0_lat", valid_at, 4);
      check("s0_cnt", valid_cnt, 1);
      check("s0_idx", palette_idx, 7);
      check("s0_bg", is_background, 0);
      check("s0_ch", is_chooser, 0);

      // Overlap: slot1 at (98,52); pixel (104,55) -> slot0 addr 324, slot1 addr 4096+3*64+6=4294
      rom_mem[4294] = 5'd9;
      cfg(2'd1, 10'd98, 10'd52);
      cfg(2'd3, 10'd3, 10'd0);
      pixel(10'd104, 10'd55);
      check("ov_addr0", seen_addr0, 324);
      check("ov_addr1", seen_addr1, 4294);
      check("ov_d1_idx", palette_idx, 9);
      check("ov_d1_bg", is_background, 0);
      rom_mem[324] = 5'd4;
      pixel(10'd104, 10'd55);
      check("ov_d0_idx", palette_idx, 4);

      // Chooser box at (200,200)
      cfg(2'd2, 10'd200, 10'd200);
      cfg(2'd3, 10'd7, 10'd0);
      pixel(10'd201, 10'd230);
      check("ch_edge", is_chooser, 1);
      check("ch_edge_bg", is_background, 0);
      pixel(10'd210, 10'd230);
      check("ch_inner_bg", is_background, 1);
      check("ch_inner_ch", is_chooser, 0);
      pixel(10'd263, 10'd230);
      check("ch_right", is_chooser, 1);
      // Chooser over slot0 at (190,225): dx=11, dy=5 -> 331
      rom_mem[331] = 5'd7;
      cfg(2'd0, 10'd190, 10'd225);
      pixel(10'd201, 10'd230);
      check("ch_over_addr", seen_addr0, 331);
      check("ch_over_ch", is_chooser, 1);
      check("ch_over_idx", palette_idx, 0);
      check("ch_over_bg", is_background, 0);
      check("pre_overrun", overrun, 0);

      // Overrun: second strobe two cycles after the first
      @(negedge Clk);
      pixel_en = 1'b1; DrawX = 10'd210; DrawY = 10'd230;
      valid_at = 0; valid_cnt = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge Clk);
         if (out_valid) begin
            valid_cnt++;
            if (valid_at == 0) valid_at = i;
         end
         pixel_en = (i == 2);
         if (i == 3) check("orun_set", overrun, 1);
      end
      check("orun_lat", valid_at, 4);
      check("orun_cnt", valid_cnt, 1);
      check("orun_state", o_dbg_state, 0);

      // Right edge of slot0 at x0=600
      rom_mem[63] = 5'd12;
      cfg(2'd0, 10'd600, 10'd50);
      cfg(2'd3, 10'd1, 10'd0);
      pixel(10'd663, 10'd50);
      check("edge_hit_addr", seen_addr0, 63);
      check("edge_hit_idx", palette_idx, 12);
      check("edge_hit_bg", is_background, 0);
      pixel(10'd664, 10'd50);
      check("edge_miss_addr", seen_addr0, 0);
      check("edge_miss_bg", is_background, 1);
      check("edge_miss_idx", palette_idx, 0);
      check("orun_sticky", overrun, 1);

      // Both slots disabled: reads still issued, latency unchanged
      cfg(2'd3, 10'd0, 10'd0);
      pixel(10'd663, 10'd50);
      check("dis_lat", valid_at, 4);
      check("dis_addr", seen_addr0, 0);
      check("dis_bg", is_background, 1);

      // Reset while in RD1
      cfg(2'd3, 10'd1, 10'd0);
      @(negedge Clk);
      pixel_en = 1'b1; DrawX = 10'd663; DrawY = 10'd50;
      @(negedge Clk);
      pixel_en = 1'b0;
      @(negedge Clk);
      check("mid_in_rd1", o_dbg_state, 2);
      Reset_n = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      check("mid_state", o_dbg_state, 0);
      valid_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         if (out_valid) valid_cnt++;
      end
      check("mid_no_valid", valid_cnt, 0);
      check("mid_overrun", overrun, 0);
      check("mid_addr", rom_addr, 0);
      check("mid_bg", is_background, 1);

      // Config was cleared by reset: slot0 sits at (0,0) once enabled, dx=5 dy=5 -> 325
      rom_mem[325] = 5'd3;
      cfg(2'd3, 10'd1, 10'd0);
      pixel(10'd5, 10'd5);
      check("post_lat", valid_at, 4);
      check("post_addr", seen_addr0, 325);
      check("post_idx", palette_idx, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
